// File: rtl/punc_defines.sv
// Shared encodings for the PUNC multicycle controller:
// opcodes, datapath mux selects, FSM states and the control bundle.
package punc_defines;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] MR_PC  = 2'b00;
  localparam logic [1:0] MR_ALU = 2'b01;
  localparam logic [1:0] MR_LDI = 2'b10;

  localparam logic MW_ALU = 1'b0;
  localparam logic MW_STI = 1'b1;

  localparam logic WD_R0 = 1'b0;
  localparam logic WD_R1 = 1'b1;

  localparam logic [1:0] RA0_SR1 = 2'b00;
  localparam logic [1:0] RA0_DR  = 2'b01;
  localparam logic [1:0] RA0_R7  = 2'b10;

  localparam logic RA1_SR2 = 1'b0;
  localparam logic RA1_DR  = 1'b1;

  localparam logic WA_DR = 1'b0;
  localparam logic WA_R7 = 1'b1;

  localparam logic [1:0] RW_ALU = 2'b00;
  localparam logic [1:0] RW_MEM = 2'b01;
  localparam logic [1:0] RW_PC  = 2'b10;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_ALU = 2'b01;
  localparam logic [1:0] PC_R0  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic IN1_R0 = 1'b0;
  localparam logic IN1_PC = 1'b1;

  localparam logic [2:0] IN2_R1    = 3'b000;
  localparam logic [2:0] IN2_IMM5  = 3'b001;
  localparam logic [2:0] IN2_OFF9  = 3'b010;
  localparam logic [2:0] IN2_OFF11 = 3'b011;
  localparam logic [2:0] IN2_OFF6  = 3'b100;

  localparam logic CC_ALU = 1'b0;
  localparam logic CC_MEM = 1'b1;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_ld;
    logic       reg_w_en;
    logic       mem_w_en;
    logic       cc;
    logic       ldi1;
    logic       sti1;
    logic [1:0] mem_raddr;
    logic       mem_waddr;
    logic       w_data_mem;
    logic [1:0] raddr0;
    logic       raddr1;
    logic       waddr;
    logic [1:0] wdata;
    logic [1:0] pc_mux;
    logic [1:0] alu;
    logic       in1;
    logic [2:0] in2;
    logic       nzp;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/punc_control.sv
// PUNC multicycle controller: FETCH/DECODE/EXEC[/EXEC2] sequencing
// with control decoded combinationally from state and ir.
module punc_control
  import punc_defines::*;
#(
  parameter logic [7:0] HALT_VEC = 8'h25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic        reg_w_en_sig,
  output logic        mem_w_en_sig,
  output logic        cc_sig,
  output logic        ldi1_sig,
  output logic        sti1_sig,
  output logic [1:0]  mem_raddr_sig,
  output logic        mem_waddr_sig,
  output logic        w_data_mem_sig,
  output logic [1:0]  reg_raddr0_sig,
  output logic        reg_raddr1_sig,
  output logic        reg_waddr_sig,
  output logic [1:0]  reg_wdata_sig,
  output logic [1:0]  pc_mux,
  output logic [1:0]  alu_sig,
  output logic        alu_input1_sig,
  output logic [2:0]  alu_input2_sig,
  output logic        nzp_mux,
  output logic        halted
);

  state_t     state;
  ctrl_t      c;
  logic [3:0] op;
  logic       is_ind;
  logic       is_halt;
  logic       take;

  assign op      = ir[15:12];
  assign is_ind  = (op == OP_LDI) || (op == OP_STI);
  assign is_halt = (op == OP_TRAP) && (ir[7:0] == HALT_VEC);
  assign take    = (ir[11] & N) | (ir[10] & Z) | (ir[9] & P);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      unique case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          unique case (1'b1)
            is_ind:  state <= S_EXEC2;
            is_halt: state <= S_HALT;
            default: state <= S_FETCH;
          endcase
        end
        S_EXEC2:  state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Everything is held low while reset is asserted, even in FETCH.
  always_comb begin
    c = '0;
    if (rst) begin
      unique case (state)
        S_FETCH: begin
          c.mem_raddr = MR_PC;
          c.ir_ld     = 1'b1;
          c.pc_ld     = 1'b1;
          c.pc_mux    = PC_INC;
        end
        S_DECODE: ;
        S_EXEC: begin
          unique case (op)
            OP_ADD, OP_AND: begin
              c.alu      = (op == OP_AND) ? ALU_AND : ALU_ADD;
              c.raddr0   = RA0_SR1;
              c.raddr1   = RA1_SR2;
              c.in1      = IN1_R0;
              c.in2      = ir[5] ? IN2_IMM5 : IN2_R1;
              c.reg_w_en = 1'b1;
              c.waddr    = WA_DR;
              c.wdata    = RW_ALU;
              c.cc       = 1'b1;
              c.nzp      = CC_ALU;
            end
            OP_NOT: begin
              c.alu      = ALU_NOT;
              c.raddr0   = RA0_SR1;
              c.in1      = IN1_R0;
              c.reg_w_en = 1'b1;
              c.waddr    = WA_DR;
              c.wdata    = RW_ALU;
              c.cc       = 1'b1;
              c.nzp      = CC_ALU;
            end
            OP_BR: begin
              c.alu    = ALU_ADD;
              c.in1    = IN1_PC;
              c.in2    = IN2_OFF9;
              c.pc_mux = PC_ALU;
              c.pc_ld  = take;
            end
            OP_JMP: begin
              c.raddr0 = RA0_SR1;
              c.pc_mux = PC_R0;
              c.pc_ld  = 1'b1;
            end
            OP_JSR: begin
              // R7 gets the old PC at the same edge the PC is replaced.
              c.reg_w_en = 1'b1;
              c.waddr    = WA_R7;
              c.wdata    = RW_PC;
              c.pc_ld    = 1'b1;
              if (ir[11]) begin
                c.alu    = ALU_ADD;
                c.in1    = IN1_PC;
                c.in2    = IN2_OFF11;
                c.pc_mux = PC_ALU;
              end else begin
                c.raddr0 = RA0_SR1;
                c.pc_mux = PC_R0;
              end
            end
            OP_LD, OP_LDR: begin
              c.alu       = ALU_ADD;
              c.mem_raddr = MR_ALU;
              if (op == OP_LD) begin
                c.in1 = IN1_PC;
                c.in2 = IN2_OFF9;
              end else begin
                c.raddr0 = RA0_SR1;
                c.in1    = IN1_R0;
                c.in2    = IN2_OFF6;
              end
              c.reg_w_en = 1'b1;
              c.waddr    = WA_DR;
              c.wdata    = RW_MEM;
              c.cc       = 1'b1;
              c.nzp      = CC_MEM;
            end
            OP_LEA: begin
              c.alu      = ALU_ADD;
              c.in1      = IN1_PC;
              c.in2      = IN2_OFF9;
              c.reg_w_en = 1'b1;
              c.waddr    = WA_DR;
              c.wdata    = RW_ALU;
            end
            OP_ST: begin
              c.alu        = ALU_ADD;
              c.in1        = IN1_PC;
              c.in2        = IN2_OFF9;
              c.raddr0     = RA0_DR;
              c.mem_w_en   = 1'b1;
              c.mem_waddr  = MW_ALU;
              c.w_data_mem = WD_R0;
            end
            OP_STR: begin
              c.alu        = ALU_ADD;
              c.raddr0     = RA0_SR1;
              c.in1        = IN1_R0;
              c.in2        = IN2_OFF6;
              c.raddr1     = RA1_DR;
              c.mem_w_en   = 1'b1;
              c.mem_waddr  = MW_ALU;
              c.w_data_mem = WD_R1;
            end
            OP_LDI, OP_STI: begin
              c.alu       = ALU_ADD;
              c.in1       = IN1_PC;
              c.in2       = IN2_OFF9;
              c.mem_raddr = MR_ALU;
              c.ldi1      = (op == OP_LDI);
              c.sti1      = (op == OP_STI);
            end
            OP_RTI, OP_RES, OP_TRAP: ;
          endcase
        end
        S_EXEC2: begin
          if (op == OP_LDI) begin
            c.mem_raddr = MR_LDI;
            c.reg_w_en  = 1'b1;
            c.waddr     = WA_DR;
            c.wdata     = RW_MEM;
            c.cc        = 1'b1;
            c.nzp       = CC_MEM;
          end else begin
            c.raddr0     = RA0_DR;
            c.mem_w_en   = 1'b1;
            c.mem_waddr  = MW_STI;
            c.w_data_mem = WD_R0;
          end
        end
        S_HALT: c.halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign ir_ld          = c.ir_ld;
  assign pc_ld          = c.pc_ld;
  assign reg_w_en_sig   = c.reg_w_en;
  assign mem_w_en_sig   = c.mem_w_en;
  assign cc_sig         = c.cc;
  assign ldi1_sig       = c.ldi1;
  assign sti1_sig       = c.sti1;
  assign mem_raddr_sig  = c.mem_raddr;
  assign mem_waddr_sig  = c.mem_waddr;
  assign w_data_mem_sig = c.w_data_mem;
  assign reg_raddr0_sig = c.raddr0;
  assign reg_raddr1_sig = c.raddr1;
  assign reg_waddr_sig  = c.waddr;
  assign reg_wdata_sig  = c.wdata;
  assign pc_mux         = c.pc_mux;
  assign alu_sig        = c.alu;
  assign alu_input1_sig = c.in1;
  assign alu_input2_sig = c.in2;
  assign nzp_mux        = c.nzp;
  assign halted         = c.halted;

endmodule

// File: doc/punc_control.md
PUNC_CONTROL -- requirements
Module: punc_control

Interface
REQ-001 SHALL have parameter HALT_VEC, default 8'h25, meaning the trapvect8 value that halts; every other TRAP executes as a NOP.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ir, input, 16 bits: current instruction from the datapath.
REQ-005 SHALL have ports N, Z, P, inputs, 1 bit each: datapath condition codes.
REQ-006 SHALL have ports ir_ld, pc_ld, reg_w_en_sig, mem_w_en_sig, cc_sig, ldi1_sig, sti1_sig, outputs, 1 bit each: load/write enables.
REQ-007 SHALL have port mem_raddr_sig, output, 2 bits: 00 PC, 01 ALU out, 10 LDI pointer register.
REQ-008 SHALL have ports mem_waddr_sig and w_data_mem_sig, outputs, 1 bit each:
  - mem_waddr_sig: 0 ALU out, 1 STI pointer register.
  - w_data_mem_sig: 0 rdata0, 1 rdata1.
REQ-009 SHALL have ports reg_raddr0_sig (2 bits) and reg_raddr1_sig (1 bit), outputs:
  - reg_raddr0_sig: 00 ir[8:6], 01 ir[11:9], 10 R7.
  - reg_raddr1_sig: 0 ir[2:0], 1 ir[11:9].
REQ-010 SHALL have ports reg_waddr_sig (1 bit) and reg_wdata_sig (2 bits), outputs:
  - reg_waddr_sig: 0 ir[11:9], 1 R7.
  - reg_wdata_sig: 00 ALU, 01 memory rdata0, 10 PC.
REQ-011 SHALL have port pc_mux, output, 2 bits: 00 PC+1, 01 ALU out, 10 rdata0.
REQ-012 SHALL have ports alu_sig (2 bits), alu_input1_sig (1 bit) and alu_input2_sig (3 bits), outputs:
  - alu_sig: 00 ADD, 01 AND, 10 NOT.
  - alu_input1_sig: 0 rdata0, 1 PC.
  - alu_input2_sig: 000 rdata1, 001 imm5, 010 PCoff9, 011 PCoff11, 100 off6.
REQ-013 SHALL have port nzp_mux, output, 1 bit: CC source, 0 ALU, 1 memory rdata0.
REQ-014 SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-015 SHALL implement a registered-state FSM with states FETCH, DECODE, EXEC, EXEC2 and HALT; all outputs SHALL be combinational from state and ir.
REQ-016 SHALL drive every output at 0 unless it is asserted explicitly for the current state; DECODE SHALL assert nothing.
REQ-017 In FETCH, SHALL assert mem_raddr=00, ir_ld and pc_ld with pc_mux=00, then go to DECODE.
REQ-018 In DECODE, SHALL go to EXEC for all opcodes; in EXEC, SHALL go to EXEC2 for LDI/STI, to HALT for TRAP with ir[7:0]==HALT_VEC, and to FETCH otherwise.
REQ-019 ADD/AND SHALL select raddr0=00, input1=rdata0, input2 = imm5 if ir[5]=1 else rdata1 with raddr1=0, write ir[11:9], wdata=00, cc_sig=1 with nzp_mux=0.
REQ-020 NOT SHALL select alu_sig=10 on rdata0 (ir[8:6]), write ir[11:9], and update CC from the ALU.
REQ-021 BR SHALL assert pc_ld with pc_mux=01 (PC+PCoff9) only when (ir[11]&N)|(ir[10]&Z)|(ir[9]&P); ir[11:9]=000 SHALL never branch.
REQ-022 JMP/RET SHALL load PC from rdata0 with raddr0=00.
REQ-023 JSR (ir[11]=1) SHALL load PC with PC+PCoff11, and JSRR SHALL load PC from rdata0; both SHALL write PC (old value) to R7 in the same cycle, and JSRR with BaseR=R7 SHALL jump to the old R7.
REQ-024 LD SHALL read at PC+PCoff9, LDR SHALL read at rdata0+off6, and LEA SHALL write PC+PCoff9; LD/LDR SHALL update CC with nzp_mux=1, while LEA SHALL leave CC unchanged.
REQ-025 ST SHALL write at PC+PCoff9, and STR SHALL write at rdata0 (ir[8:6])+off6; the write data SHALL be ir[11:9], taken from rdata0 (raddr0=01) for ST and from rdata1 (raddr1=1, w_data_mem_sig=1) for STR.
REQ-026 LDI SHALL take two cycles:
  - EXEC: read at PC+PCoff9 with ldi1_sig=1.
  - EXEC2: read with mem_raddr=10, write ir[11:9], update CC from memory.
REQ-027 STI SHALL take two cycles:
  - EXEC: read at PC+PCoff9 with sti1_sig=1.
  - EXEC2: mem_waddr=1, write rdata0 from ir[11:9].
REQ-028 RTI and reserved opcode 1101 SHALL execute as NOPs.
REQ-029 Instruction latency SHALL be 3 cycles, or 4 cycles for LDI/STI.
REQ-030 HALT SHALL be absorbing, with halted=1 and no enables asserted.

Reset
REQ-031 When rst=0, SHALL force state to FETCH asynchronously, with all enables 0 and halted=0, including mid-instruction in EXEC2.
REQ-032 In the first clk edge after rst rises, SHALL perform FETCH; the datapath SHALL share the same reset.

Structure
REQ-033 Opcode constants, mux-select encodings and the state encoding SHALL reside in the shared package punc_defines.
REQ-034 SHALL be a single module with no sub-module.

Verification
REQ-035 A bench SHALL check: mem[0]=ADD R1,R0,#5 with R0=0 -> R1=5 after 3 cycles; N/Z/P=0/0/1; PC=1.
REQ-036 A bench SHALL check: BRz +3 at PC=4 with Z=1 -> PC=8; the same instruction with Z=0 -> PC=5.
REQ-037 A bench SHALL check: LDI R2 with mem[PC+off]=0x0010 and mem[0x0010]=0xFFFE -> R2=0xFFFE and N=1 after 4 cycles.
REQ-038 A bench SHALL check: STR R3,R4,#2 with R4=0x20 and R3=0xABCD -> mem[0x22]=0xABCD.
REQ-039 A bench SHALL check: JSRR R7 with R7=0x30 at PC=9 -> PC=0x30 and R7=0x000A.
REQ-040 A bench SHALL check: TRAP x25 -> halted=1 and PC stays fixed; rst pulsed low in EXEC2 of STI -> no memory write and FETCH follows.
